// File: rtl/crypto_pkg.sv
// Shared types and constants for the nibble XOR stream-cipher cell.
package crypto_pkg;
  localparam int KEY_W = 4;
  typedef logic [KEY_W-1:0] nibble_t;
  localparam nibble_t DEFAULT_KEY_C = 4'b0000;
endpackage

// File: rtl/crypto_xor4.sv
// Combinational 4-bit XOR of a data nibble with a key nibble.
module crypto_xor4
  import crypto_pkg::*;
(
  input  nibble_t data_i,
  input  nibble_t key_i,
  output nibble_t res_o
);
  assign res_o = data_i ^ key_i;
endmodule

// File: rtl/crypto_core.sv
// XOR stream-cipher cell: key register plus one registered result stage.
module crypto_core
  import crypto_pkg::*;
#(
  parameter nibble_t DEFAULT_KEY = DEFAULT_KEY_C
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a,
  input  logic         b,
  input  logic         c,
  input  logic         d,
  input  logic         in_valid,
  input  logic [3:0]   key_in,
  input  logic         key_we,
  output logic         y3,
  output logic         y2,
  output logic         y1,
  output logic         y0,
  output logic         out_valid
);
  // Result path reads KEYVAL directly so a forced key shows up in the next capture.
  nibble_t KEYVAL;
  nibble_t data_w;
  nibble_t res_w;
  nibble_t y_q, y_d;
  logic    vld_q, vld_d;

  assign data_w = {a, b, c, d};

  crypto_xor4 u_xor (
    .data_i (data_w),
    .key_i  (KEYVAL),
    .res_o  (res_w)
  );

  always_comb begin
    y_d   = y_q;
    vld_d = in_valid;
    if (in_valid) y_d = res_w;
  end

  // Key load and result capture share the edge, so a same-cycle load is seen one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      KEYVAL <= DEFAULT_KEY;
      y_q    <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (key_we) KEYVAL <= key_in;
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign {y3, y2, y1, y0} = y_q;
  assign out_valid        = vld_q;
endmodule

// File: tb/tb_crypto_core.sv
// Scoreboard bench for crypto_core: expectations queued at drive time, checked after each edge.
module tb_crypto_core;
  localparam logic [3:0] DEF_K = 4'b1001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] key_in = 4'b0;
  logic       key_we = 1'b0;
  logic       y3, y2, y1, y0, out_valid;

  crypto_core #(.DEFAULT_KEY(DEF_K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .in_valid  (in_valid),
    .key_in    (key_in),
    .key_we    (key_we),
    .y3        (y3),
    .y2        (y2),
    .y1        (y1),
    .y0        (y0),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [3:0] y;
    logic [3:0] key;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] km = DEF_K;
  logic [3:0] ym = 4'b0;
  logic [3:0] frc_val = 4'b0;
  logic       frc_on = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rstv, input logic vld, input logic [3:0] dat,
                       input logic kwe, input logic [3:0] kin, input logic frc);
    @(negedge clk);
    if (frc) begin
      frc_val = kin;
      km      = kin;
      if (!frc_on) begin
        force dut.KEYVAL = frc_val;
        frc_on = 1'b1;
      end
    end else if (frc_on) begin
      release dut.KEYVAL;
      frc_on = 1'b0;
    end
    rst_n        = rstv;
    in_valid     = vld;
    {a, b, c, d} = dat;
    key_we       = kwe & ~frc;
    key_in       = kin;
    if (!rstv) begin
      ym = 4'b0;
      km = DEF_K;
    end else begin
      if (vld) ym = dat ^ km;
      if (kwe && !frc) km = kin;
    end
    sb.push_back('{vld: vld & rstv, y: ym, key: km});
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("out_valid", {7'b0, out_valid}, {7'b0, mon_e.vld});
      chk("y", {4'b0, y3, y2, y1, y0}, {4'b0, mon_e.y});
      chk("keyval", {4'b0, dut.KEYVAL}, {4'b0, mon_e.key});
    end
  end

  initial begin
    // Reset held two cycles with valid and key write asserted.
    drive(1'b0, 1'b1, 4'hF, 1'b1, 4'h6, 1'b0);
    drive(1'b0, 1'b1, 4'hA, 1'b1, 4'h5, 1'b0);
    // First data after reset uses the default key.
    drive(1'b1, 1'b1, 4'b0101, 1'b0, 4'h0, 1'b0);

    // Exhaustive sweep with keys loaded through key_we.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 4'h0, 1'b1, 4'(k), 1'b0);
      for (int dv = 0; dv < 16; dv++)
        drive(1'b1, 1'b1, 4'(dv), 1'b0, 4'h0, 1'b0);
    end

    // Exhaustive sweep with KEYVAL forced.
    for (int k = 0; k < 16; k++)
      for (int dv = 0; dv < 16; dv++)
        drive(1'b1, 1'b1, 4'(dv), 1'b0, 4'(k), 1'b1);
    drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b1111, 1'b0);

    // Same-cycle key change: old key for this data, new key next cycle.
    drive(1'b1, 1'b1, 4'b1000, 1'b1, 4'b0001, 1'b0);
    drive(1'b1, 1'b1, 4'b1000, 1'b0, 4'h0, 1'b0);

    // Round-trip with a hold gap in between.
    drive(1'b1, 1'b0, 4'h0, 1'b1, 4'b0110, 1'b0);
    drive(1'b1, 1'b1, 4'b1100, 1'b0, 4'h0, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 4'h3, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 1'b1, 4'b1010, 1'b0, 4'h0, 1'b0);

    // Reset mid-stream.
    drive(1'b1, 1'b1, 4'b0011, 1'b1, 4'b0100, 1'b0);
    drive(1'b1, 1'b1, 4'b1110, 1'b0, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 4'b0111, 1'b1, 4'b1100, 1'b0);
    drive(1'b1, 1'b1, 4'b0111, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
